// File: rtl/fetch_pkg.sv
// Shared constants and the response-buffer entry type for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer: synchronous FIFO of fetched {addr, inst} pairs with flush.
// Write is registered; the head entry is read combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_occ,
  output logic         o_empty,
  output logic         o_full
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_occ     = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC ownership, credit-limited imem requests, response buffering,
// stall and redirect handling. Optional sticky misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] Addr,
  output logic [31:0] Inst,
  output logic        InstValid,
  output logic        FetchStall,
  output logic        MisalignTrap
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_last_addr;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [31:0]   w_target;
  logic [CW-1:0] w_occ;
  logic          w_empty;
  logic          w_fifo_full_unused;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_trap;
  logic          w_hs;
  logic          w_credit;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_inst_valid;

  assign w_target = {BranchTarget[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_trap;

  always_ff @(posedge clk) begin
    if (rst)                                  r_trap <= 1'b0;
    else if (BranchTaken && |BranchTarget[1:0]) r_trap <= 1'b1;
  end

  assign w_trap = r_trap;
`else
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^BranchTarget[1:0];
  assign w_trap           = 1'b0;
`endif

  // Requests in flight plus buffered words never exceed BUF_DEPTH, so a response
  // always has a FIFO slot and a raised request cannot lose its credit before acceptance.
  assign w_credit       = (r_outstanding + w_occ) < CW'(BUF_DEPTH);
  assign imem_req_valid = !rst && !BranchTaken && !w_trap && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid && imem_req_ready;

  assign w_drop       = (r_drop_cnt != '0);
  assign w_push       = imem_rsp_valid && !w_drop && !BranchTaken && !w_trap;
  assign w_push_data  = '{addr: r_rsp_pc, inst: imem_rsp_data};
  assign w_inst_valid = !w_empty && !w_trap;
  assign w_pop        = !Stall && w_inst_valid && !BranchTaken;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (BranchTaken),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_occ   (w_occ),
    .o_empty (w_empty),
    .o_full  (w_fifo_full_unused)
  );

  assign InstValid    = w_inst_valid;
  assign Inst         = w_inst_valid ? w_head.inst : NOP_INST;
  assign Addr         = w_inst_valid ? w_head.addr : r_last_addr;
  assign FetchStall   = w_empty && !BranchTaken;
  assign MisalignTrap = w_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_last_addr   <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_hs) - CW'(imem_rsp_valid);
      if (w_inst_valid) r_last_addr <= w_head.addr;
      if (BranchTaken) begin
        // Everything still in flight after this cycle's response is wrong-path.
        r_pc       <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
      end else begin
        if (w_hs)                    r_pc       <= r_pc + 32'd4;
        if (w_push)                  r_rsp_pc   <= r_rsp_pc + 32'd4;
        if (imem_rsp_valid && w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of selectable latency.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        InstValid;
  logic        FetchStall;
  logic        MisalignTrap;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Stall          (Stall),
    .BranchTaken    (BranchTaken),
    .BranchTarget   (BranchTarget),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .Addr           (Addr),
    .Inst           (Inst),
    .InstValid      (InstValid),
    .FetchStall     (FetchStall),
    .MisalignTrap   (MisalignTrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One cycle: drive controls at the falling edge, accept a request, deliver the due response.
  // mem_lat is the number of cycles after the accepting cycle (0 = same cycle).
  task automatic drive(input logic stall, input logic br, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    rst            = 1'b0;
    Stall          = stall;
    BranchTaken    = br;
    BranchTarget   = tgt;
    imem_req_ready = rdy;
    imem_rsp_valid = 1'b0;
    #1;
    if (imem_req_valid && rdy) mq.push_back('{cyc + mem_lat, imem_req_addr});
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst            = 1'b1;
    Stall          = 1'b0;
    BranchTaken    = 1'b0;
    BranchTarget   = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    repeat (2) @(negedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (Addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", Addr); end
    checks++; if (Inst !== 32'h13) begin errors++; $display("FAIL reset_inst got %h exp 00000013", Inst); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL reset_instvalid got %b exp 0", InstValid); end
    checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL reset_fetchstall got %b exp 1", FetchStall); end
    checks++; if (MisalignTrap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b exp 0", MisalignTrap); end
  endtask

  task automatic test_stream();
    apply_reset();
    mem_lat = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL stream_c0_instvalid got %b exp 0", InstValid); end
    checks++; if (FetchStall !== 1'b1) begin errors++; $display("FAIL stream_c0_fetchstall got %b exp 1", FetchStall); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL stream_c0_req got %b/%h exp 1/00000000", imem_req_valid, imem_req_addr); end
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (InstValid !== 1'b1) begin errors++; $display("FAIL stream_instvalid c%0d got %b exp 1", c, InstValid); end
      checks++; if (Addr !== 32'(4 * (c - 1))) begin errors++; $display("FAIL stream_addr c%0d got %h exp %h", c, Addr, 32'(4 * (c - 1))); end
      checks++; if (Inst !== mem_word(32'(4 * (c - 1)))) begin errors++; $display("FAIL stream_inst c%0d got %h exp %h", c, Inst, mem_word(32'(4 * (c - 1)))); end
      checks++; if (imem_req_addr !== 32'(4 * c)) begin errors++; $display("FAIL stream_req_addr c%0d got %h exp %h", c, imem_req_addr, 32'(4 * c)); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    mem_lat = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (Addr !== 32'h4 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++; $display("FAIL stall_c2 got addr %h req %b/%h exp 4 1/8", Addr, imem_req_valid, imem_req_addr); end
    for (int c = 3; c <= 4; c++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (Addr !== 32'h4 || Inst !== mem_word(32'h4)) begin errors++; $display("FAIL stall_frozen c%0d got %h/%h exp 4/%h", c, Addr, Inst, mem_word(32'h4)); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid c%0d got %b exp 0", c, imem_req_valid); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (Addr !== 32'h4 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_resume_c5 got %h/%b exp 4/0", Addr, imem_req_valid); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (Addr !== 32'h8 || Inst !== mem_word(32'h8) || imem_req_addr !== 32'hC) begin errors++; $display("FAIL stall_resume_c6 got %h/%h req %h exp 8/%h req c", Addr, Inst, imem_req_addr, mem_word(32'h8)); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (Addr !== 32'hC) begin errors++; $display("FAIL stall_resume_c7 got %h exp c", Addr); end
  endtask

  task automatic test_not_ready();
    apply_reset();
    mem_lat = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL notready_req c%0d got %b/%h exp 1/0", c, imem_req_valid, imem_req_addr); end
      checks++; if (Inst !== 32'h13 || InstValid !== 1'b0 || FetchStall !== 1'b1) begin errors++; $display("FAIL notready_out c%0d got %h %b %b exp 13 0 1", c, Inst, InstValid, FetchStall); end
      checks++; if (Addr !== 32'h0) begin errors++; $display("FAIL notready_addr c%0d got %h exp 0", c, Addr); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b1 || Inst !== mem_word(32'h0) || Addr !== 32'h0) begin errors++; $display("FAIL notready_first got %b %h %h exp 1 %h 0", InstValid, Inst, Addr, mem_word(32'h0)); end
  endtask

  task automatic test_redirect();
    apply_reset();
    mem_lat = 2;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h100, 1'b1);
    checks++; if (imem_req_valid !== 1'b0 || FetchStall !== 1'b0) begin errors++; $display("FAIL redir_c2 got req %b fstall %b exp 0 0", imem_req_valid, FetchStall); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_c3_req got %b/%h exp 1/100", imem_req_valid, imem_req_addr); end
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL redir_c3_drop got %b exp 0", InstValid); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b0 || imem_req_addr !== 32'h104) begin errors++; $display("FAIL redir_c4 got %b req %h exp 0 104", InstValid, imem_req_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL redir_c5 got %b exp 0", InstValid); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b1 || Addr !== 32'h100 || Inst !== mem_word(32'h100)) begin errors++; $display("FAIL redir_c6 got %b %h %h exp 1 100 %h", InstValid, Addr, Inst, mem_word(32'h100)); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (Addr !== 32'h104) begin errors++; $display("FAIL redir_c7 got %h exp 104", Addr); end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    mem_lat = 1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h200, 1'b1);
    checks++; if (InstValid !== 1'b1 || Addr !== 32'h0 || FetchStall !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstall_c2 got %b %h %b %b exp 1 0 0 0", InstValid, Addr, FetchStall, imem_req_valid); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b0 || Inst !== 32'h13 || FetchStall !== 1'b1) begin errors++; $display("FAIL rstall_c3_empty got %b %h %b exp 0 13 1", InstValid, Inst, FetchStall); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rstall_c3_req got %b/%h exp 1/200", imem_req_valid, imem_req_addr); end
    checks++; if (Addr !== 32'h0) begin errors++; $display("FAIL rstall_c3_addr got %h exp 0", Addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b0) begin errors++; $display("FAIL rstall_c4 got %b exp 0", InstValid); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b1 || Addr !== 32'h200 || Inst !== mem_word(32'h200)) begin errors++; $display("FAIL rstall_c5 got %b %h %h exp 1 200 %h", InstValid, Addr, Inst, mem_word(32'h200)); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (Addr !== 32'h204) begin errors++; $display("FAIL rstall_c6 got %h exp 204", Addr); end
  endtask

  task automatic test_misalign();
    apply_reset();
    mem_lat = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h102, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (MisalignTrap !== 1'b1 || InstValid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL misalign_c2 got %b %b %b exp 1 0 0", MisalignTrap, InstValid, imem_req_valid); end
    for (int c = 3; c <= 5; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (MisalignTrap !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL misalign_hold c%0d got %b %b exp 1 0", c, MisalignTrap, imem_req_valid); end
    end
`else
    checks++; if (MisalignTrap !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL misalign_c2 got %b %b %h exp 0 1 100", MisalignTrap, imem_req_valid, imem_req_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (InstValid !== 1'b1 || Addr !== 32'h100) begin errors++; $display("FAIL misalign_c3 got %b %h exp 1 100", InstValid, Addr); end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    Stall          = 1'b0;
    BranchTaken    = 1'b0;
    BranchTarget   = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    test_reset();
    test_stream();
    test_stall();
    test_not_ready();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
